// File: rtl/fpga_core_pkg.sv
// Shared constants and helpers for the fpga_core fabric slice.
package fpga_core_pkg;

   localparam int unsigned IO_SIZE_DEF  = 144;
   localparam int unsigned SCAN_LEN_DEF = 2304;

   // Each pad owns two consecutive config bits: direction then invert.
   localparam int unsigned DIR_OFS = 0;
   localparam int unsigned INV_OFS = 1;

   function automatic int unsigned cfg_len(input int unsigned io_size);
      return 2 * io_size;
   endfunction

endpackage

// File: rtl/fpga_core_shift_chain.sv
// Async-reset serial shift register with enable and parallel load (load wins over shift).
module fpga_core_shift_chain #(
   parameter int unsigned LEN = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           load,
   input  logic           sin,
   input  logic [LEN-1:0] pin,
   output logic [LEN-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= load ? pin : {q[LEN-2:0], sin};
      end
   end

endmodule

// File: rtl/fpga_core.sv
// Fabric core: user/scan flop array, config chain, isolated pad interface.
// Optional SCAN_TAIL_RETIME_EN adds a retiming flop on sc_tail.
module fpga_core
   import fpga_core_pkg::*;
#(
   parameter int unsigned IO_SIZE  = IO_SIZE_DEF,
   parameter int unsigned SCAN_LEN = SCAN_LEN_DEF
) (
   input  logic               clk,
   input  logic               Reset,
   input  logic               Test_en,
   input  logic               prog_en,
   input  logic               ccff_head,
   output logic               ccff_tail,
   input  logic               sc_head,
   output logic               sc_tail,
   input  logic               IO_ISOL_N,
   input  logic [IO_SIZE-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
   output logic [IO_SIZE-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
   output logic [IO_SIZE-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR
);

   localparam int unsigned CFG_LEN = cfg_len(IO_SIZE);

   logic [CFG_LEN-1:0]  cfg;
   logic [SCAN_LEN-1:0] ff;
   logic [SCAN_LEN-1:0] ff_load;
   logic [IO_SIZE-1:0]  dir;
   logic [IO_SIZE-1:0]  inv;
   logic [IO_SIZE-1:0]  isol_mask;

   for (genvar i = 0; i < IO_SIZE; i++) begin : g_pad_cfg
      assign dir[i] = cfg[2*i+DIR_OFS];
      assign inv[i] = cfg[2*i+INV_OFS];
   end

   // Functional mode: first IO_SIZE flops capture pads, the rest form per-pad pipelines.
   if (SCAN_LEN > IO_SIZE) begin : g_pipe
      assign ff_load = {ff[SCAN_LEN-IO_SIZE-1:0], gfpga_pad_EMBEDDED_IO_HD_SOC_IN ^ inv};
   end else begin : g_nopipe
      assign ff_load = gfpga_pad_EMBEDDED_IO_HD_SOC_IN ^ inv;
   end

   fpga_core_shift_chain #(
      .LEN (SCAN_LEN)
   ) u_scan_chain (
      .clk  (clk),
      .rst  (Reset),
      .en   (1'b1),
      .load (~Test_en),
      .sin  (sc_head),
      .pin  (ff_load),
      .q    (ff)
   );

   fpga_core_shift_chain #(
      .LEN (CFG_LEN)
   ) u_cfg_chain (
      .clk  (clk),
      .rst  (Reset),
      .en   (prog_en),
      .load (1'b0),
      .sin  (ccff_head),
      .pin  ({CFG_LEN{1'b0}}),
      .q    (cfg)
   );

   assign ccff_tail = cfg[CFG_LEN-1];

`ifdef SCAN_TAIL_RETIME_EN
   logic sc_tail_q;

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         sc_tail_q <= 1'b0;
      end else if (Test_en) begin
         sc_tail_q <= ff[SCAN_LEN-1];
      end
   end

   assign sc_tail = sc_tail_q;
`else
   assign sc_tail = ff[SCAN_LEN-1];
`endif

   assign isol_mask = {IO_SIZE{IO_ISOL_N}};
   assign gfpga_pad_EMBEDDED_IO_HD_SOC_DIR = dir & isol_mask;
   assign gfpga_pad_EMBEDDED_IO_HD_SOC_OUT = ff[SCAN_LEN-1 -: IO_SIZE] & dir & isol_mask;

endmodule

// File: tb/tb_fpga_core.sv
// Scoreboard bench for fpga_core: driver queues cycle-tagged expectations, monitor checks them.
module tb_fpga_core;

   localparam int unsigned IO = 144;
   localparam int unsigned SL = 2304;
`ifdef SCAN_TAIL_RETIME_EN
   localparam int PULSE_AT = SL + 2;
`else
   localparam int PULSE_AT = SL + 1;
`endif

   logic          clk;
   logic          Reset;
   logic          Test_en;
   logic          prog_en;
   logic          ccff_head;
   logic          ccff_tail;
   logic          sc_head;
   logic          sc_tail;
   logic          IO_ISOL_N;
   logic [IO-1:0] pad_in;
   logic [IO-1:0] pad_out;
   logic [IO-1:0] pad_dir;

   fpga_core #(
      .IO_SIZE  (IO),
      .SCAN_LEN (SL)
   ) dut (
      .clk                              (clk),
      .Reset                            (Reset),
      .Test_en                          (Test_en),
      .prog_en                          (prog_en),
      .ccff_head                        (ccff_head),
      .ccff_tail                        (ccff_tail),
      .sc_head                          (sc_head),
      .sc_tail                          (sc_tail),
      .IO_ISOL_N                        (IO_ISOL_N),
      .gfpga_pad_EMBEDDED_IO_HD_SOC_IN  (pad_in),
      .gfpga_pad_EMBEDDED_IO_HD_SOC_OUT (pad_out),
      .gfpga_pad_EMBEDDED_IO_HD_SOC_DIR (pad_dir)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int            cyc;
      int            kind;
      logic [IO-1:0] val;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic string kname(input int k);
      case (k)
         0:       return "sc_tail";
         1:       return "ccff_tail";
         2:       return "pad_dir";
         default: return "pad_out";
      endcase
   endfunction

   // Sorted insert keeps the queue ordered by check cycle.
   function automatic void expect_at(input int c, input int k, input logic [IO-1:0] v);
      exp_t e;
      int   idx;
      e.cyc  = c;
      e.kind = k;
      e.val  = v;
      idx = sb.size();
      while (idx > 0 && sb[idx-1].cyc > c) idx--;
      sb.insert(idx, e);
   endfunction

   // Monitor: sample mid-cycle, after the posedge numbered cyc.
   always @(negedge clk) begin
      exp_t          e;
      logic [IO-1:0] act;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         n_checks++;
         case (e.kind)
            0:       act = {{(IO-1){1'b0}}, sc_tail};
            1:       act = {{(IO-1){1'b0}}, ccff_tail};
            2:       act = pad_dir;
            default: act = pad_out;
         endcase
         if (e.cyc < cyc) begin
            n_fail++;
            $display("FAIL %s cyc %0d: check missed (now %0d)", kname(e.kind), e.cyc, cyc);
         end else if (act !== e.val) begin
            n_fail++;
            $display("FAIL %s cyc %0d: got %h expected %h", kname(e.kind), e.cyc, act, e.val);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Shift 288 config bits so that only pad 0 has dir=1 and inv=inv0.
   task automatic load_cfg(input logic inv0);
      prog_en = 1'b1;
      for (int s = 0; s < 2 * IO; s++) begin
         ccff_head = (s == 2 * IO - 1) ? 1'b1 : (s == 2 * IO - 2) ? inv0 : 1'b0;
         tick();
      end
      prog_en   = 1'b0;
      ccff_head = 1'b0;
   endtask

   initial begin
      int base;
      Reset     = 1'b1;
      Test_en   = 1'b0;
      prog_en   = 1'b0;
      ccff_head = 1'b0;
      sc_head   = 1'b0;
      IO_ISOL_N = 1'b1;
      pad_in    = '0;
      tick();
      tick();
      for (int k = 0; k < 4; k++) expect_at(cyc, k, '0);
      Reset = 1'b0;
      tick();

      // Scan pulse: sc_head high for posedge 1 only.
      Test_en = 1'b1;
      sc_head = 1'b1;
      base    = cyc;
      for (int p = 1; p <= SL + 4; p++) expect_at(base + p - 1, 0, IO'(p == PULSE_AT));
      tick();
      sc_head = 1'b0;
      repeat (SL + 4) tick();

      // Reset at cycle 1000 wipes the pulse in flight.
      Reset = 1'b1;
      tick();
      Reset   = 1'b0;
      sc_head = 1'b1;
      base    = cyc;
      for (int p = 1; p <= 2400; p++) expect_at(base + p - 1, 0, '0);
      tick();
      sc_head = 1'b0;
      repeat (998) tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      repeat (1401) tick();

      // Config load: pad 0 output, no invert; then isolation.
      load_cfg(1'b0);
      expect_at(cyc, 2, IO'(1));
      expect_at(cyc, 3, '0);
      tick();
      IO_ISOL_N = 1'b0;
      expect_at(cyc, 2, '0);
      expect_at(cyc, 3, '0);
      tick();
      IO_ISOL_N = 1'b1;

      // Functional path: all pads pulse, only pad 0 reaches OUT 16 cycles later.
      Test_en = 1'b0;
      pad_in  = '1;
      base    = cyc;
      expect_at(base + 15, 3, '0);
      expect_at(base + 16, 3, IO'(1));
      expect_at(base + 17, 3, '0);
      tick();
      pad_in = '0;
      repeat (20) tick();

      // Inverted pad 0: idle level 1, pulse appears as a 0.
      Test_en = 1'b1;
      load_cfg(1'b1);
      Test_en = 1'b0;
      repeat (20) tick();
      expect_at(cyc, 3, IO'(1));
      tick();
      pad_in = IO'(1);
      base   = cyc;
      expect_at(base + 15, 3, IO'(1));
      expect_at(base + 16, 3, '0);
      expect_at(base + 17, 3, IO'(1));
      tick();
      pad_in = '0;
      repeat (17) tick();
      IO_ISOL_N = 1'b0;
      expect_at(cyc, 3, '0);
      expect_at(cyc, 2, '0);
      tick();
      IO_ISOL_N = 1'b1;

      // ccff passthrough: 288 ones then zeros, scan chain shifting at the same time.
      Reset = 1'b1;
      tick();
      Reset     = 1'b0;
      Test_en   = 1'b1;
      prog_en   = 1'b1;
      ccff_head = 1'b1;
      base      = cyc;
      expect_at(base + 2 * IO - 1, 1, '0);
      expect_at(base + 2 * IO, 1, IO'(1));
      expect_at(base + 2 * IO, 2, '1);
      expect_at(base + 2 * IO, 3, '0);
      expect_at(base + 4 * IO - 1, 1, IO'(1));
      expect_at(base + 4 * IO, 1, '0);
      repeat (2 * IO) tick();
      ccff_head = 1'b0;
      repeat (2 * IO + 2) tick();
      prog_en = 1'b0;

      for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
      if (sb.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d checks left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fpga_core.md
Name: fpga_core

Overview:
- Simplified FPGA fabric core with three parts:
  - a user-register array that also forms a scan chain (sc_head→sc_tail);
  - a configuration shift chain (ccff_head→ccff_tail) holding per-pad direction/invert bits;
  - an I/O pad interface gated by an isolation input.
- Sits under the SoC wrapper.
- Scan test: a single pulse at sc_head must emerge at sc_tail exactly SCAN_LEN cycles later.

Parameters:
- IO_SIZE, 144, number of I/O pads.
- SCAN_LEN, 2304, number of user/scan flops. Must be an integer multiple of IO_SIZE, with SCAN_LEN ≥ IO_SIZE.
- CFG_LEN, 2*IO_SIZE, derived length of the configuration chain. Not overridable.

Ports:
- clk  in  1  single clock for all state.
- Reset  in  1  asynchronous, active-high reset.
- Test_en  in  1  1 = scan shift mode; 0 = functional mode.
- prog_en  in  1  1 = shift the configuration chain this cycle.
- ccff_head  in  1  configuration chain serial input.
- ccff_tail  out  1  configuration chain serial output (cfg[CFG_LEN-1]).
- sc_head  in  1  scan chain serial input.
- sc_tail  out  1  scan chain serial output (ff[SCAN_LEN-1]).
- IO_ISOL_N  in  1  active-low pad isolation; 0 forces all pad outputs off.
- gfpga_pad_EMBEDDED_IO_HD_SOC_IN  in  IO_SIZE  pad inputs to the fabric.
- gfpga_pad_EMBEDDED_IO_HD_SOC_OUT  out  IO_SIZE  fabric outputs to the pads.
- gfpga_pad_EMBEDDED_IO_HD_SOC_DIR  out  IO_SIZE  per-pad output enable (1 = fabric drives).

Behaviour:
- Reset=1 (asynchronous): ff[0..SCAN_LEN-1]=0 and cfg[0..CFG_LEN-1]=0. Hence sc_tail=0, ccff_tail=0, OUT=0, DIR=0.
- Config chain, posedge clk with prog_en=1: cfg[0]<=ccff_head, cfg[j]<=cfg[j-1]. With prog_en=0, cfg holds.
  - Independent of Test_en.
  - ccff_tail=cfg[CFG_LEN-1] (registered, no combinational path).
- Pad bit mapping: dir[i]=cfg[2i], inv[i]=cfg[2i+1].
- Scan mode, posedge clk with Test_en=1: ff[0]<=sc_head, ff[k]<=ff[k-1].
  - sc_tail=ff[SCAN_LEN-1].
  - Latency: a value sampled from sc_head at posedge n is visible on sc_tail after posedge n+SCAN_LEN-1, i.e. it is read as 1 at posedge n+SCAN_LEN, before that edge's update.
- Functional mode, posedge clk with Test_en=0:
  - k<IO_SIZE: ff[k]<=IN[k]^inv[k].
  - k≥IO_SIZE: ff[k]<=ff[k-IO_SIZE], a SCAN_LEN/IO_SIZE-stage pipeline per pad.
- Pad outputs (combinational from registers and IO_ISOL_N):
  - DIR[i]=dir[i]&IO_ISOL_N.
  - OUT[i]=ff[SCAN_LEN-IO_SIZE+i]&dir[i]&IO_ISOL_N.
- Mode change mid-stream: takes effect at the next edge; no flush.
- Reset mid-shift: chain contents are lost immediately.
- Simultaneous prog_en=1 and Test_en=1: both chains shift in the same cycle.
- X on sc_head propagates unchanged. Nothing is masked.

Optional Feature:
- Macro SCAN_TAIL_RETIME_EN.
- Defined:
  - sc_tail comes from an extra flop clocked by clk, reset to 0, loaded from ff[SCAN_LEN-1] every cycle when Test_en=1 and holding otherwise.
  - Scan latency becomes SCAN_LEN+1.
- Undefined: sc_tail=ff[SCAN_LEN-1] directly, with latency SCAN_LEN.

Decomposition:
- Package fpga_core_pkg:
  - default IO_SIZE and SCAN_LEN constants;
  - localparam function for CFG_LEN;
  - cfg bit-index helpers (DIR_OFS=0, INV_OFS=1).
- One natural sub-module: fpga_core_shift_chain, a parameterised async-reset serial shift register with enable and a parallel-load option, instantiated for both the scan and config chains.

Test Plan:
- Scan pulse:
  - Stimulus: Reset high 1 cycle, then Test_en=1; sc_head=1 for exactly the first post-reset posedge, 0 after.
  - Response: sc_tail reads 0 at posedges 1..2304, 1 at posedge 2305, 0 at posedges 2306..2308.
- Reset mid-shift: assert Reset at cycle 1000 of the scan pulse test → sc_tail stays 0 through cycle 2400.
- Config load:
  - Stimulus: prog_en=1 for 288 cycles shifting pattern dir=1, inv=0 for pad 0 only; IO_ISOL_N=1.
  - Response: DIR=…0001b (pad 0 only). With IO_ISOL_N=0, DIR=0 and OUT=0.
- Functional path:
  - Stimulus: pad 0 configured as output, Test_en=0, IN[0] pulse of 1 cycle.
  - Response: OUT[0] pulses after 16 cycles (2304/144). With inv[0]=1 the pulse is inverted.
- ccff passthrough: shift 288 ones then zeros with prog_en=1 → ccff_tail first reads 1 at posedge 289.
- Retime macro: with SCAN_TAIL_RETIME_EN defined, rerun the scan pulse test → sc_tail reads 1 at posedge 2306 only.
